// File: rtl/bp_pkg.sv
// BytePipe initiator shared definitions: command byte layout, FSM state
// encoding and the tag carried for every outstanding transaction.
// Optional macro: BP_INITIATOR_CHECK_EN (adds the expected value to the tag).
package bp_pkg;

    localparam int BP_CMD_WR_BIT = 7;
    localparam int BP_ADDR_W     = 7;
    localparam logic [BP_ADDR_W-1:0] BP_ADDR_BURST = 7'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } bp_state_e;

    typedef struct packed {
        logic                 wr;
        logic [BP_ADDR_W-1:0] addr;
`ifdef BP_INITIATOR_CHECK_EN
        logic [7:0]           exp;
`endif
    } bp_tag_t;

    localparam int BP_TAG_W = $bits(bp_tag_t);

endpackage

// File: rtl/bp_tag_fifo.sv
// In-order tag FIFO: one entry per transaction issued on BytePipe and not yet
// answered. Read data is show-ahead (head entry visible while not empty).
module bp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cg,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array: written on push, no reset needed for payload
    always_ff @(posedge i_clk) begin
        if (i_cg && i_push)
            mem_q[wptr_q] <= i_data;
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (i_cg) begin
            if (i_push) wptr_q <= ptr_inc(wptr_q);
            if (i_pop)  rptr_q <= ptr_inc(rptr_q);
            case ({i_push, i_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign o_data  = mem_q[rptr_q];
    assign o_full  = (cnt_q == CNT_W'(DEPTH));
    assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/bp_initiator.sv
// Host-side BytePipe initiator: serialises register requests into a command
// byte (plus a data byte for writes) and pairs each returned byte with its
// request, in order, through a tag FIFO.
// Optional macro: BP_INITIATOR_CHECK_EN adds i_req_expect / o_rsp_mismatch.
module bp_initiator
    import bp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cg,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wr,
    input  logic [BP_ADDR_W-1:0] i_req_addr,
    input  logic [7:0]           i_req_wdata,
`ifdef BP_INITIATOR_CHECK_EN
    input  logic [7:0]           i_req_expect,
    output logic                 o_rsp_mismatch,
`endif
    output logic [7:0]           o_bp_data,
    output logic                 o_bp_valid,
    input  logic                 i_bp_ready,
    input  logic [7:0]           i_bp_data,
    input  logic                 i_bp_valid,
    output logic                 o_bp_ready,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [7:0]           o_rsp_data,
    output logic                 o_rsp_wr,
    output logic [BP_ADDR_W-1:0] o_rsp_addr,
    output logic                 o_err
);

    bp_state_e  state_q, state_d;
    logic [7:0] cmd_q, wdata_q;
    logic       req_fire, bp_fire, rsp_take, tag_pop;
    logic       fifo_full, fifo_empty;
    bp_tag_t    push_tag, head_tag;
    logic       rsp_valid_q, rsp_wr_q, err_q;
    logic [7:0] rsp_data_q;
    logic [BP_ADDR_W-1:0] rsp_addr_q;

    // Nothing is accepted on either side while the clock gate is closed, so no
    // handshake can complete without the state that records it advancing.
    assign o_req_ready = i_cg && (state_q == IDLE) && !fifo_full;
    assign req_fire    = i_req_valid && o_req_ready;
    assign bp_fire     = i_cg && i_bp_ready;

    assign push_tag.wr   = i_req_wr;
    assign push_tag.addr = i_req_addr;
`ifdef BP_INITIATOR_CHECK_EN
    assign push_tag.exp  = i_req_expect;
`endif

    // Command FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else if (i_cg)
            state_q <= state_d;
    end

    // Command FSM next state: reads end after the command byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = CMD;
            CMD:     if (bp_fire)  state_d = cmd_q[BP_CMD_WR_BIT] ? DATA : IDLE;
            DATA:    if (bp_fire)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command FSM outputs: bytes come straight from held registers, so they
    // stay stable while the responder stalls
    always_comb begin
        o_bp_valid = 1'b0;
        o_bp_data  = '0;
        case (state_q)
            CMD: begin
                o_bp_valid = 1'b1;
                o_bp_data  = cmd_q;
            end
            DATA: begin
                o_bp_valid = 1'b1;
                o_bp_data  = wdata_q;
            end
            default: ;
        endcase
    end

    // Capture the request bytes at acceptance
    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            cmd_q   <= {i_req_wr, i_req_addr};
            wdata_q <= i_req_wdata;
        end
    end

    bp_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (BP_TAG_W)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_cg    (i_cg),
        .i_push  (req_fire),
        .i_data  (push_tag),
        .i_pop   (tag_pop),
        .o_data  (head_tag),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Single-entry response register: a byte can be taken whenever the slot
    // is free or being drained this cycle
    assign o_bp_ready = i_cg && (!rsp_valid_q || i_rsp_ready);
    assign rsp_take   = i_bp_valid && o_bp_ready;
    assign tag_pop    = rsp_take && !fifo_empty;

    // Response slot load/drain and sticky unsolicited-byte error
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_addr_q  <= '0;
            err_q       <= 1'b0;
        end else if (i_cg) begin
            if (tag_pop) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= i_bp_data;
                rsp_wr_q    <= head_tag.wr;
                rsp_addr_q  <= head_tag.addr;
            end else if (i_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (rsp_take && fifo_empty)
                err_q <= 1'b1;
        end
    end

`ifdef BP_INITIATOR_CHECK_EN
    logic mismatch_q;

    // Compare the returned old value against the host's expectation (writes only)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            mismatch_q <= 1'b0;
        else if (i_cg && tag_pop)
            mismatch_q <= head_tag.wr && (i_bp_data != head_tag.exp);
    end

    assign o_rsp_mismatch = mismatch_q;
`endif

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_wr    = rsp_wr_q;
    assign o_rsp_addr  = rsp_addr_q;
    assign o_err       = err_q;

endmodule
